// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Shared types and constants for the fetch PC generator (pc_gen, pc_ras).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h1000;
    localparam int          STEP_C           = 2;
    localparam int          STEP_I           = 4;

    // Redirect targets must be halfword aligned, or word aligned without compressed support.
    function automatic logic target_misaligned(input logic [1:0] lo, input logic c_ext);
        return lo[0] | (~c_ext & lo[1]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_gen_if.sv
// ============================================================================
// Module : pc_gen_if
// Control/redirect inputs and fetch-address outputs of pc_gen; RAS signals
// exist only when PC_GEN_RAS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_gen_if #(
    parameter int XLEN    = 64,
    parameter int EPOCH_W = 2
);
    logic               stall;
    logic               trap_en;
    logic [XLEN-1:0]    trap_pc;
    logic               bj_en;
    logic [XLEN-1:0]    bj_pc;
    logic               halt_req;
    logic               inst_valid;
    logic               inst_comp;
    logic [XLEN-1:0]    pc;
    logic               pc_valid;
    logic               redirect;
    logic [EPOCH_W-1:0] epoch;
    logic               misalign;
    logic [XLEN-1:0]    misalign_pc;
`ifdef PC_GEN_RAS_EN
    logic               ras_push;
    logic               ras_pop;
    logic [XLEN-1:0]    ras_push_pc;
`endif

    modport master (
`ifdef PC_GEN_RAS_EN
        output ras_push, output ras_pop, output ras_push_pc,
`endif
        output stall, output trap_en, output trap_pc, output bj_en, output bj_pc,
        output halt_req, output inst_valid, output inst_comp,
        input  pc, input pc_valid, input redirect, input epoch,
        input  misalign, input misalign_pc
    );

    modport slave (
`ifdef PC_GEN_RAS_EN
        input  ras_push, input ras_pop, input ras_push_pc,
`endif
        input  stall, input trap_en, input trap_pc, input bj_en, input bj_pc,
        input  halt_req, input inst_valid, input inst_comp,
        output pc, output pc_valid, output redirect, output epoch,
        output misalign, output misalign_pc
    );

endinterface

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module : pc_ras
// Circular return-address stack; overflow overwrites the oldest entry.
// Instantiated by pc_gen only when PC_GEN_RAS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            clear,
    input  wire logic            push,
    input  wire logic            pop,
    input  wire logic [XLEN-1:0] push_pc,
    output logic      [XLEN-1:0] top_pc,
    output logic                 empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  stack_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_ptr;

    // pop is already qualified by the caller as a non-empty pop.
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        w_wr_en  = 1'b0;
        w_wr_ptr = ptr_q;
        if (clear) begin
            cnt_d = '0;
        end else if (push && pop) begin
            w_wr_en = 1'b1;
        end else if (push) begin
            ptr_d    = ptr_q + PTR_W'(1);
            w_wr_ptr = ptr_q + PTR_W'(1);
            w_wr_en  = 1'b1;
            if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) stack_q[w_wr_ptr] <= push_pc;
    end

    assign top_pc = stack_q[ptr_q];
    assign empty  = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module : pc_gen
// Fetch PC generator: BOOT/RUN/HALT FSM, trap/branch redirects with epoch,
// redirect alignment check. Optional return-address stack via PC_GEN_RAS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          C_EXT     = 1,
    parameter int          EPOCH_W   = 2,
    parameter int          RAS_DEPTH = 4
) (
    input wire logic clk,
    input wire logic rst,
    pc_gen_if.slave  bus
);
    localparam logic [XLEN-1:0] RST_PC   = XLEN'(RESET_PC);
    localparam logic            C_EXT_EN = (C_EXT != 0);

    pc_state_e          state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               pc_valid_q, pc_valid_d;
    logic               redirect_q, redirect_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               misalign_q, misalign_d;
    logic [XLEN-1:0]    misalign_pc_q, misalign_pc_d;
    logic [XLEN-1:0]    w_seq_pc;
    logic               w_bj_bad;

    assign w_seq_pc = pc_q + ((C_EXT_EN && bus.inst_comp) ? XLEN'(STEP_C) : XLEN'(STEP_I));
    assign w_bj_bad = target_misaligned(bus.bj_pc[1:0], C_EXT_EN);

`ifdef PC_GEN_RAS_EN
    logic            w_ras_take;
    logic            w_ras_empty;
    logic [XLEN-1:0] w_ras_top;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.trap_en && (state_q != ST_BOOT)),
        .push    (bus.ras_push),
        .pop     (w_ras_take),
        .push_pc (bus.ras_push_pc),
        .top_pc  (w_ras_top),
        .empty   (w_ras_empty)
    );
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_d    = 1'b0;
        epoch_d       = epoch_q;
        misalign_d    = 1'b0;
        misalign_pc_d = misalign_pc_q;
`ifdef PC_GEN_RAS_EN
        w_ras_take    = 1'b0;
`endif
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.trap_en) begin
                    pc_d       = bus.trap_pc;
                    redirect_d = 1'b1;
                    epoch_d    = epoch_q + EPOCH_W'(1);
                end else begin
                    if (bus.bj_en) begin
                        if (w_bj_bad) begin
                            misalign_d    = 1'b1;
                            misalign_pc_d = bus.bj_pc;
                        end else begin
                            pc_d       = bus.bj_pc;
                            redirect_d = 1'b1;
                            epoch_d    = epoch_q + EPOCH_W'(1);
                        end
                    end else if (bus.stall || !bus.inst_valid) begin
                        pc_d = pc_q;
`ifdef PC_GEN_RAS_EN
                    end else if (bus.ras_pop && !w_ras_empty) begin
                        pc_d       = w_ras_top;
                        w_ras_take = 1'b1;
                        redirect_d = 1'b1;
                        epoch_d    = epoch_q + EPOCH_W'(1);
`endif
                    end else begin
                        pc_d = w_seq_pc;
                    end
                    if (bus.halt_req) state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (bus.trap_en) begin
                    pc_d       = bus.trap_pc;
                    redirect_d = 1'b1;
                    epoch_d    = epoch_q + EPOCH_W'(1);
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        pc_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RST_PC;
            pc_valid_q    <= 1'b0;
            redirect_q    <= 1'b0;
            epoch_q       <= '0;
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            redirect_q    <= redirect_d;
            epoch_q       <= epoch_d;
            misalign_q    <= misalign_d;
            misalign_pc_q <= misalign_pc_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.redirect    = redirect_q;
    assign bus.epoch       = epoch_q;
    assign bus.misalign    = misalign_q;
    assign bus.misalign_pc = misalign_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module : tb_pc_gen
// Vector-table bench for pc_gen (C_EXT=1 and C_EXT=0 instances); RAS
// sequence included when PC_GEN_RAS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    typedef struct {
        logic        st, tr;
        logic [63:0] tpc;
        logic        bj;
        logic [63:0] bpc;
        logic        hr, iv, ic;
        logic        rpush, rpop;
        logic [63:0] rpc;
        logic [63:0] e_pc;
        logic        e_v, e_r;
        logic [1:0]  e_ep;
        logic        e_m;
        logic [63:0] e_mpc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t drv_a, drv_b;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(64), .EPOCH_W(2)) bus_a ();
    pc_gen_if #(.XLEN(64), .EPOCH_W(2)) bus_b ();

    assign bus_a.stall = drv_a.st;  assign bus_a.trap_en = drv_a.tr;  assign bus_a.trap_pc = drv_a.tpc;
    assign bus_a.bj_en = drv_a.bj;  assign bus_a.bj_pc = drv_a.bpc;   assign bus_a.halt_req = drv_a.hr;
    assign bus_a.inst_valid = drv_a.iv; assign bus_a.inst_comp = drv_a.ic;
    assign bus_b.stall = drv_b.st;  assign bus_b.trap_en = drv_b.tr;  assign bus_b.trap_pc = drv_b.tpc;
    assign bus_b.bj_en = drv_b.bj;  assign bus_b.bj_pc = drv_b.bpc;   assign bus_b.halt_req = drv_b.hr;
    assign bus_b.inst_valid = drv_b.iv; assign bus_b.inst_comp = drv_b.ic;
`ifdef PC_GEN_RAS_EN
    assign bus_a.ras_push = drv_a.rpush; assign bus_a.ras_pop = drv_a.rpop; assign bus_a.ras_push_pc = drv_a.rpc;
    assign bus_b.ras_push = drv_b.rpush; assign bus_b.ras_pop = drv_b.rpop; assign bus_b.ras_push_pc = drv_b.rpc;
`endif

    pc_gen #(.XLEN(64), .RESET_PC(64'h1000), .C_EXT(1), .EPOCH_W(2), .RAS_DEPTH(4)) dut_a (
        .clk (clk), .rst (rst_a), .bus (bus_a)
    );
    pc_gen #(.XLEN(64), .RESET_PC(64'h1000), .C_EXT(0), .EPOCH_W(2), .RAS_DEPTH(4)) dut_b (
        .clk (clk), .rst (rst_b), .bus (bus_b)
    );

    function automatic vec_t v(input logic st, tr, input logic [63:0] tpc, input logic bj,
                               input logic [63:0] bpc, input logic hr, iv, ic,
                               input logic [63:0] e_pc, input logic e_v, e_r,
                               input logic [1:0] e_ep, input logic e_m, input logic [63:0] e_mpc);
        vec_t r;
        r.st = st; r.tr = tr; r.tpc = tpc; r.bj = bj; r.bpc = bpc; r.hr = hr; r.iv = iv; r.ic = ic;
        r.rpush = 1'b0; r.rpop = 1'b0; r.rpc = '0;
        r.e_pc = e_pc; r.e_v = e_v; r.e_r = e_r; r.e_ep = e_ep; r.e_m = e_m; r.e_mpc = e_mpc;
        return r;
    endfunction

    function automatic vec_t vr(input logic push, pop, input logic [63:0] rpc, input logic iv,
                                input logic [63:0] e_pc, input logic e_r, input logic [1:0] e_ep);
        vec_t r = v(0, 0, 0, 0, 0, 0, iv, 0, e_pc, 1, e_r, e_ep, 0, 0);
        r.rpush = push; r.rpop = pop; r.rpc = rpc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t x, input bit on_b);
        if (on_b) begin
            check({tag, ".pc"}, bus_b.pc, x.e_pc);
            check({tag, ".pc_valid"}, 64'(bus_b.pc_valid), 64'(x.e_v));
            check({tag, ".redirect"}, 64'(bus_b.redirect), 64'(x.e_r));
            check({tag, ".epoch"}, 64'(bus_b.epoch), 64'(x.e_ep));
            check({tag, ".misalign"}, 64'(bus_b.misalign), 64'(x.e_m));
            check({tag, ".misalign_pc"}, bus_b.misalign_pc, x.e_mpc);
        end else begin
            check({tag, ".pc"}, bus_a.pc, x.e_pc);
            check({tag, ".pc_valid"}, 64'(bus_a.pc_valid), 64'(x.e_v));
            check({tag, ".redirect"}, 64'(bus_a.redirect), 64'(x.e_r));
            check({tag, ".epoch"}, 64'(bus_a.epoch), 64'(x.e_ep));
            check({tag, ".misalign"}, 64'(bus_a.misalign), 64'(x.e_m));
            check({tag, ".misalign_pc"}, bus_a.misalign_pc, x.e_mpc);
        end
    endtask

    task automatic apply(input vec_t x, input bit on_b, input string tag);
        if (on_b) drv_b = x; else drv_a = x;
        @(posedge clk);
        #1;
        check_outs(tag, x, on_b);
    endtask

    vec_t tab_a [20];
    vec_t tab_b [7];
    vec_t idle;
    vec_t rst_exp;

    initial begin
        idle    = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_exp = v(0, 0, 0, 0, 0, 0, 0, 0, 64'h1000, 0, 0, 0, 0, 0);
        drv_a = idle;
        drv_b = idle;

        //            st tr tpc          bj bpc                     hr iv ic  pc                      v  r  ep m  mpc
        tab_a[0]  = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h1000,               1, 0, 0, 0, 0);
        tab_a[1]  = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h1004,               1, 0, 0, 0, 0);
        tab_a[2]  = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h1008,               1, 0, 0, 0, 0);
        tab_a[3]  = v(0, 0, 0,           1, 64'h2000,               0, 1, 0,  64'h2000,               1, 1, 1, 0, 0);
        tab_a[4]  = v(0, 0, 0,           0, 0,                      0, 1, 1,  64'h2002,               1, 0, 1, 0, 0);
        tab_a[5]  = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h2006,               1, 0, 1, 0, 0);
        tab_a[6]  = v(0, 0, 0,           0, 0,                      0, 0, 0,  64'h2006,               1, 0, 1, 0, 0);
        tab_a[7]  = v(1, 0, 0,           0, 0,                      0, 1, 0,  64'h2006,               1, 0, 1, 0, 0);
        tab_a[8]  = v(1, 1, 64'h8000,    1, 64'h4000,               0, 1, 0,  64'h8000,               1, 1, 2, 0, 0);
        tab_a[9]  = v(0, 0, 0,           1, 64'h4001,               0, 1, 0,  64'h8000,               1, 0, 2, 1, 64'h4001);
        tab_a[10] = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h8004,               1, 0, 2, 0, 64'h4001);
        tab_a[11] = v(0, 0, 0,           1, 64'h4002,               0, 1, 0,  64'h4002,               1, 1, 3, 0, 64'h4001);
        tab_a[12] = v(0, 1, 64'h200,     0, 0,                      1, 1, 0,  64'h200,                1, 1, 0, 0, 64'h4001);
        tab_a[13] = v(0, 0, 0,           0, 0,                      1, 1, 0,  64'h204,                0, 0, 0, 0, 64'h4001);
        tab_a[14] = v(0, 0, 0,           1, 64'h3000,               0, 1, 0,  64'h204,                0, 0, 0, 0, 64'h4001);
        tab_a[15] = v(0, 0, 0,           0, 0,                      1, 1, 0,  64'h204,                0, 0, 0, 0, 64'h4001);
        tab_a[16] = v(0, 1, 64'h100,     0, 0,                      0, 0, 0,  64'h100,                1, 1, 1, 0, 64'h4001);
        tab_a[17] = v(0, 0, 0,           1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 2, 0, 64'h4001);
        tab_a[18] = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h0,                  1, 0, 2, 0, 64'h4001);
        tab_a[19] = v(0, 0, 0,           0, 0,                      0, 1, 1,  64'h2,                  1, 0, 2, 0, 64'h4001);

        tab_b[0]  = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h1000,               1, 0, 0, 0, 0);
        tab_b[1]  = v(0, 0, 0,           1, 64'h2000,               0, 1, 0,  64'h2000,               1, 1, 1, 0, 0);
        tab_b[2]  = v(0, 0, 0,           0, 0,                      0, 1, 1,  64'h2004,               1, 0, 1, 0, 0);
        tab_b[3]  = v(0, 0, 0,           0, 0,                      0, 1, 0,  64'h2008,               1, 0, 1, 0, 0);
        tab_b[4]  = v(0, 0, 0,           1, 64'h4002,               0, 1, 0,  64'h2008,               1, 0, 1, 1, 64'h4002);
        tab_b[5]  = v(0, 0, 0,           1, 64'h4001,               0, 1, 0,  64'h2008,               1, 0, 1, 1, 64'h4001);
        tab_b[6]  = v(0, 0, 0,           0, 0,                      0, 1, 1,  64'h200C,               1, 0, 1, 0, 64'h4001);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_a", rst_exp, 1'b0);
        check_outs("reset_b", rst_exp, 1'b1);

        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) apply(tab_a[i], 1'b0, $sformatf("A%0d", i));
        drv_a = idle;

        // Asynchronous reset taken between clock edges must act immediately.
        #2;
        rst_a = 1'b1;
        #1;
        check_outs("async_rst", rst_exp, 1'b0);
        @(posedge clk);
        #1;

        rst_b = 1'b0;
        for (int i = 0; i < 7; i++) apply(tab_b[i], 1'b1, $sformatf("B%0d", i));
        drv_b = idle;

`ifdef PC_GEN_RAS_EN
        rst_a = 1'b0;
        apply(vr(0, 0, 0,     0, 64'h1000, 0, 0), 1'b0, "R_boot");
        apply(vr(1, 0, 64'h10, 0, 64'h1000, 0, 0), 1'b0, "R_push0");
        apply(vr(1, 0, 64'h20, 0, 64'h1000, 0, 0), 1'b0, "R_push1");
        apply(vr(1, 0, 64'h30, 0, 64'h1000, 0, 0), 1'b0, "R_push2");
        apply(vr(1, 0, 64'h40, 0, 64'h1000, 0, 0), 1'b0, "R_push3");
        apply(vr(1, 0, 64'h50, 0, 64'h1000, 0, 0), 1'b0, "R_push4");
        apply(vr(0, 1, 0,     1, 64'h50,   1, 1), 1'b0, "R_pop0");
        apply(vr(0, 1, 0,     1, 64'h40,   1, 2), 1'b0, "R_pop1");
        apply(vr(0, 1, 0,     1, 64'h30,   1, 3), 1'b0, "R_pop2");
        apply(vr(0, 1, 0,     1, 64'h20,   1, 0), 1'b0, "R_pop3");
        apply(vr(0, 1, 0,     1, 64'h24,   0, 0), 1'b0, "R_pop4_empty");
        drv_a = idle;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
